// File: rtl/ecc_telemetry_collector.sv
// ECC telemetry collector: timestamped event FIFO, saturating totals, windowed SBE-rate and stuck-syndrome alarms.
// Optional DBE alarm output is enabled by defining ECC_TELEM_DBE_ALARM_EN.
module ecc_telemetry_collector #(
  parameter int ECC_WIDTH     = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int TS_WIDTH      = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SBE_THRESH    = 16,
  parameter int REPEAT_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ECC_WIDTH-1:0] ml_syndrome,
  input  logic                 ml_err_sbe,
  input  logic                 ml_err_dbe,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ECC_WIDTH-1:0] evt_syndrome,
  output logic                 evt_is_dbe,
  output logic [TS_WIDTH-1:0]  evt_timestamp,
  output logic [CNT_WIDTH-1:0] sbe_total,
  output logic [CNT_WIDTH-1:0] dbe_total,
  output logic [CNT_WIDTH-1:0] win_sbe_count,
  output logic                 alarm_rate,
  output logic                 alarm_stuck,
  output logic                 fifo_overflow,
`ifdef ECC_TELEM_DBE_ALARM_EN
  output logic                 alarm_dbe,
`endif
  input  logic                 alarm_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int RW = $clog2(REPEAT_THRESH + 1);
  localparam logic [WW-1:0]        WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_PRE = CNT_WIDTH'(SBE_THRESH - 1);
  localparam logic [RW-1:0]        REP_MAX  = RW'(REPEAT_THRESH);
  localparam logic [RW-1:0]        REP_PRE  = RW'(REPEAT_THRESH - 1);

  logic [ECC_WIDTH-1:0]  r_mem_syn [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   r_mem_ts  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_dbe;
  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic [TS_WIDTH-1:0]   r_ts;
  logic [WW-1:0]         r_win_pos;
  logic [CNT_WIDTH-1:0]  r_sbe_total, r_dbe_total, r_win_cnt;
  logic [ECC_WIDTH-1:0]  r_last_syn;
  logic [RW-1:0]         r_rep_cnt;
  logic                  r_alarm_rate, r_alarm_stuck, r_overflow;

  logic w_sbe, w_dbe, w_event, w_empty, w_full, w_pop, w_push;
  logic w_wrap, w_same_syn, w_rate_set, w_stuck_set, w_ovf_set;

  // Both flags high is classified as a DBE only.
  assign w_dbe   = ml_err_dbe;
  assign w_sbe   = ml_err_sbe & ~ml_err_dbe;
  assign w_event = w_sbe | w_dbe;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & evt_ready;
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_ovf_set = w_event & w_full & ~w_pop;

  assign w_wrap      = (r_win_pos == WIN_LAST);
  assign w_same_syn  = (ml_syndrome == r_last_syn);
  assign w_rate_set  = w_sbe && (r_win_cnt == RATE_PRE);
  assign w_stuck_set = w_sbe && w_same_syn && (r_rep_cnt == REP_PRE);

  // Head fields are masked while empty so stale storage never reaches the outputs.
  assign evt_valid     = ~w_empty;
  assign evt_syndrome  = w_empty ? '0 : r_mem_syn[r_rd_ptr[AW-1:0]];
  assign evt_is_dbe    = w_empty ? 1'b0 : r_mem_dbe[r_rd_ptr[AW-1:0]];
  assign evt_timestamp = w_empty ? '0 : r_mem_ts[r_rd_ptr[AW-1:0]];
  assign sbe_total     = r_sbe_total;
  assign dbe_total     = r_dbe_total;
  assign win_sbe_count = r_win_cnt;
  assign alarm_rate    = r_alarm_rate;
  assign alarm_stuck   = r_alarm_stuck;
  assign fifo_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_syn[r_wr_ptr[AW-1:0]] <= ml_syndrome;
      r_mem_ts[r_wr_ptr[AW-1:0]]  <= r_ts;
      r_mem_dbe[r_wr_ptr[AW-1:0]] <= w_dbe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ts          <= '0;
      r_win_pos     <= '0;
      r_sbe_total   <= '0;
      r_dbe_total   <= '0;
      r_win_cnt     <= '0;
      r_last_syn    <= '0;
      r_rep_cnt     <= '0;
      r_alarm_rate  <= 1'b0;
      r_alarm_stuck <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_sbe && (r_sbe_total != '1)) r_sbe_total <= r_sbe_total + 1'b1;
      if (w_dbe && (r_dbe_total != '1)) r_dbe_total <= r_dbe_total + 1'b1;

      // An SBE in the wrap cycle is counted toward the closing window's alarm only.
      r_win_pos <= w_wrap ? '0 : r_win_pos + 1'b1;
      if (w_wrap)                             r_win_cnt <= '0;
      else if (w_sbe && (r_win_cnt != '1))    r_win_cnt <= r_win_cnt + 1'b1;

      if (w_dbe) begin
        r_rep_cnt <= '0;
      end else if (w_sbe) begin
        if (!w_same_syn) begin
          r_last_syn <= ml_syndrome;
          r_rep_cnt  <= RW'(1);
        end else if (r_rep_cnt != REP_MAX) begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      r_alarm_rate  <= w_rate_set  | (r_alarm_rate  & ~alarm_clr);
      r_alarm_stuck <= w_stuck_set | (r_alarm_stuck & ~alarm_clr);
      r_overflow    <= w_ovf_set   | (r_overflow    & ~alarm_clr);
    end
  end

`ifdef ECC_TELEM_DBE_ALARM_EN
  logic r_alarm_dbe;
  assign alarm_dbe = r_alarm_dbe;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alarm_dbe <= 1'b0;
    else        r_alarm_dbe <= w_dbe | (r_alarm_dbe & ~alarm_clr);
  end
`endif

endmodule

// File: tb/tb_ecc_telemetry_collector.sv
// Directed self-checking bench for ecc_telemetry_collector (default parameters).
module tb_ecc_telemetry_collector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  ml_syndrome = '0;
  logic        ml_err_sbe = 1'b0, ml_err_dbe = 1'b0;
  logic        evt_valid, evt_ready = 1'b0;
  logic [7:0]  evt_syndrome;
  logic        evt_is_dbe;
  logic [15:0] evt_timestamp, sbe_total, dbe_total, win_sbe_count;
  logic        alarm_rate, alarm_stuck, fifo_overflow;
  logic        alarm_clr = 1'b0;
`ifdef ECC_TELEM_DBE_ALARM_EN
  logic        alarm_dbe;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] exp_q [8];

  ecc_telemetry_collector dut (
    .clk(clk), .rst_n(rst_n),
    .ml_syndrome(ml_syndrome), .ml_err_sbe(ml_err_sbe), .ml_err_dbe(ml_err_dbe),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_syndrome(evt_syndrome),
    .evt_is_dbe(evt_is_dbe), .evt_timestamp(evt_timestamp),
    .sbe_total(sbe_total), .dbe_total(dbe_total), .win_sbe_count(win_sbe_count),
    .alarm_rate(alarm_rate), .alarm_stuck(alarm_stuck), .fifo_overflow(fifo_overflow),
`ifdef ECC_TELEM_DBE_ALARM_EN
    .alarm_dbe(alarm_dbe),
`endif
    .alarm_clr(alarm_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic s, input logic d, input logic [7:0] syn);
    ml_err_sbe  = s;
    ml_err_dbe  = d;
    ml_syndrome = syn;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    evt_ready = 1'b0;
    alarm_clr = 1'b0;
    tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_sbe_total", 32'(sbe_total), 32'h0);
    chk("rst_dbe_total", 32'(dbe_total), 32'h0);
    chk("rst_win", 32'(win_sbe_count), 32'h0);
    chk("rst_flags", 32'({alarm_rate, alarm_stuck, fifo_overflow}), 32'h0);
    chk("rst_ts", 32'(evt_timestamp), 32'h0);
`ifdef ECC_TELEM_DBE_ALARM_EN
    chk("rst_alarm_dbe", 32'(alarm_dbe), 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // 1: three SBEs, then drain in order
    drive(1'b1, 1'b0, 8'h07); tick();
    chk("t1_valid_n1", 32'(evt_valid), 32'h1);
    chk("t1_head_syn", 32'(evt_syndrome), 32'h07);
    drive(1'b1, 1'b0, 8'h0B); tick();
    drive(1'b1, 1'b0, 8'h0D); tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("t1_sbe_total", 32'(sbe_total), 32'd3);
    evt_ready = 1'b1;
    chk("t1_pop0_syn", 32'(evt_syndrome), 32'h07);
    chk("t1_pop0_ts", 32'(evt_timestamp), 32'd0);
    chk("t1_pop0_dbe", 32'(evt_is_dbe), 32'h0);
    tick();
    chk("t1_pop1_syn", 32'(evt_syndrome), 32'h0B);
    chk("t1_pop1_ts", 32'(evt_timestamp), 32'd1);
    tick();
    chk("t1_pop2_syn", 32'(evt_syndrome), 32'h0D);
    chk("t1_pop2_ts", 32'(evt_timestamp), 32'd2);
    tick();
    chk("t1_empty", 32'(evt_valid), 32'h0);

    // 2: ten DBEs into an 8-deep FIFO, then push on full with pop
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'(8'h30 + i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("t2_overflow", 32'(fifo_overflow), 32'h1);
    chk("t2_dbe_total", 32'(dbe_total), 32'd10);
    chk("t2_head", 32'(evt_syndrome), 32'h30);
    chk("t2_head_dbe", 32'(evt_is_dbe), 32'h1);
    alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
    chk("t2_ovf_clr", 32'(fifo_overflow), 32'h0);
    chk("t2_fifo_kept", 32'(evt_valid), 32'h1);
    drive(1'b0, 1'b1, 8'hAA);
    evt_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("t2_fullpop_no_ovf", 32'(fifo_overflow), 32'h0);
    chk("t2_dbe_total11", 32'(dbe_total), 32'd11);
    for (int k = 0; k < 8; k++) exp_q[k] = (k < 7) ? 8'(8'h31 + k) : 8'hAA;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_drain%0d", k), 32'(evt_syndrome), 32'(exp_q[k]));
      tick();
    end
    chk("t2_drained", 32'(evt_valid), 32'h0);

    // 3: rate alarm inside one window, clear, then straddle a wrap
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i + 1));
      tick();
      if (i == 14) chk("t3_rate_pre", 32'(alarm_rate), 32'h0);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("t3_win16", 32'(win_sbe_count), 32'd16);
    chk("t3_rate_set", 32'(alarm_rate), 32'h1);
    alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
    chk("t3_rate_clr", 32'(alarm_rate), 32'h0);
    chk("t3_win_kept", 32'(win_sbe_count), 32'd16);
    while (cyc < 2040) tick();
    chk("t3_win_fresh", 32'(win_sbe_count), 32'd0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 8'(8'h20 + i));
      tick();
      if (i == 6) chk("t3_win_before_wrap", 32'(win_sbe_count), 32'd7);
      if (i == 7) chk("t3_win_wrap", 32'(win_sbe_count), 32'd0);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("t3_win_after", 32'(win_sbe_count), 32'd7);
    chk("t3_rate_stays0", 32'(alarm_rate), 32'h0);
    chk("t3_sbe_total", 32'(sbe_total), 32'd31);

    // 4: stuck-syndrome tracker
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h4F);
      tick();
      if (i == 2) chk("t4_stuck_pre", 32'(alarm_stuck), 32'h0);
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("t4_stuck_set", 32'(alarm_stuck), 32'h1);
    alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
    chk("t4_stuck_clr", 32'(alarm_stuck), 32'h0);
    drive(1'b0, 1'b1, 8'h00); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b0, 1'b1, 8'h00); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("t4_dbe_breaks", 32'(alarm_stuck), 32'h0);
    drive(1'b0, 1'b1, 8'h00); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b1, 1'b0, 8'h51); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b1, 1'b0, 8'h4F); tick();
    chk("t4_rep_restart", 32'(alarm_stuck), 32'h0);
    drive(1'b1, 1'b0, 8'h4F); tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("t4_rep_reach", 32'(alarm_stuck), 32'h1);

    // 5: SBE and DBE together
    do_reset();
    drive(1'b1, 1'b1, 8'h5A); tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("t5_valid", 32'(evt_valid), 32'h1);
    chk("t5_is_dbe", 32'(evt_is_dbe), 32'h1);
    chk("t5_syn", 32'(evt_syndrome), 32'h5A);
    chk("t5_dbe_total", 32'(dbe_total), 32'd1);
    chk("t5_sbe_total", 32'(sbe_total), 32'd0);
    evt_ready = 1'b1; tick();
    chk("t5_single", 32'(evt_valid), 32'h0);

`ifdef ECC_TELEM_DBE_ALARM_EN
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("cfg_dbe_set", 32'(alarm_dbe), 32'h1);
    alarm_clr = 1'b1; tick();
    chk("cfg_dbe_setwins", 32'(alarm_dbe), 32'h1);
    drive(1'b0, 1'b0, 8'h00); tick(); alarm_clr = 1'b0;
    chk("cfg_dbe_clr", 32'(alarm_dbe), 32'h0);
`endif

    // 6: reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h4F);
      tick();
    end
    chk("t6_pre_valid", 32'(evt_valid), 32'h1);
    chk("t6_pre_sbe", 32'(sbe_total), 32'd5);
    chk("t6_pre_stuck", 32'(alarm_stuck), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(evt_valid), 32'h0);
    chk("t6_sbe_total", 32'(sbe_total), 32'h0);
    chk("t6_win", 32'(win_sbe_count), 32'h0);
    chk("t6_flags", 32'({alarm_rate, alarm_stuck, fifo_overflow}), 32'h0);
    chk("t6_head", 32'({evt_syndrome, evt_timestamp}), 32'h0);
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("t6_stays_empty", 32'(evt_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
